// File: rtl/id_exe_operand_reg_pkg.sv
// Shared constants for the ID/EXE operand stage: forwarding select
// encoding, the bubble instruction and the load opcode.
package id_exe_operand_reg_pkg;

  localparam logic [1:0]  FWD_RF   = 2'd0;
  localparam logic [1:0]  FWD_EXE  = 2'd1;
  localparam logic [1:0]  FWD_MEM  = 2'd2;
  localparam logic [1:0]  FWD_WB   = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [5:0]  OP_LW    = 6'h23;

endpackage

// File: rtl/id_exe_operand_reg_if.sv
// Bundle of ID-side inputs, forwarding sources and EXE-side outputs of the
// ID/EXE operand stage; slave is the stage, master drives ID and reads EXE.
interface id_exe_operand_reg_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);
  logic          hold;
  logic          flush;
  logic          ID_valid;
  logic [DW-1:0] ID_inst;
  logic [DW-1:0] ID_pc4;
  logic [1:0]    forwardA;
  logic [1:0]    forwardB;
  logic [DW-1:0] rf_rdata_a;
  logic [DW-1:0] rf_rdata_b;
  logic [DW-1:0] EXE_result;
  logic          EXE_is_load;
  logic [DW-1:0] MEM_result;
  logic [DW-1:0] WB_result;
  logic          cnt_clr;
  logic          stall;
  logic          EXE_valid;
  logic [DW-1:0] EXE_inst;
  logic [DW-1:0] EXE_pc4;
  logic [DW-1:0] EXE_opA;
  logic [DW-1:0] EXE_opB;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport slave (
    input  hold, flush, ID_valid, ID_inst, ID_pc4, forwardA, forwardB,
           rf_rdata_a, rf_rdata_b, EXE_result, EXE_is_load, MEM_result,
           WB_result, cnt_clr,
    output stall, EXE_valid, EXE_inst, EXE_pc4, EXE_opA, EXE_opB,
           stall_cnt, flush_cnt
  );

  modport master (
    output hold, flush, ID_valid, ID_inst, ID_pc4, forwardA, forwardB,
           rf_rdata_a, rf_rdata_b, EXE_result, EXE_is_load, MEM_result,
           WB_result, cnt_clr,
    input  stall, EXE_valid, EXE_inst, EXE_pc4, EXE_opA, EXE_opB,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_exe_operand_reg_fwd_operand_mux.sv
// 4:1 operand select between register file and the EXE/MEM/WB results.
module fwd_operand_mux
  import id_exe_operand_reg_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] exe,
  input  logic [DW-1:0] mem,
  input  logic [DW-1:0] wb,
  output logic [DW-1:0] op_c
);

  always_comb begin
    op_c = rf;
    case (sel)
      FWD_EXE: op_c = exe;
      FWD_MEM: op_c = mem;
      FWD_WB:  op_c = wb;
      default: op_c = rf;
    endcase
  end

endmodule

// File: rtl/id_exe_operand_reg.sv
// ID/EXE pipeline register: resolves forwarded operands, inserts a bubble on
// load-use hazards or flushes, and keeps saturating stall/flush counters.
module id_exe_operand_reg
  import id_exe_operand_reg_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input logic               clk,
  input logic               rst,
  id_exe_operand_reg_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [DW-1:0] opa_c;
  logic [DW-1:0] opb_c;
  logic          lu_c;
  logic          bubble_c;

  logic          exe_valid;
  logic [DW-1:0] exe_inst;
  logic [DW-1:0] exe_pc4;
  logic [DW-1:0] exe_opa;
  logic [DW-1:0] exe_opb;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  fwd_operand_mux #(.DW(DW)) u_mux_a (
    .sel  (bus.forwardA),
    .rf   (bus.rf_rdata_a),
    .exe  (bus.EXE_result),
    .mem  (bus.MEM_result),
    .wb   (bus.WB_result),
    .op_c (opa_c)
  );

  fwd_operand_mux #(.DW(DW)) u_mux_b (
    .sel  (bus.forwardB),
    .rf   (bus.rf_rdata_b),
    .exe  (bus.EXE_result),
    .mem  (bus.MEM_result),
    .wb   (bus.WB_result),
    .op_c (opb_c)
  );

  // Load data is not ready until MEM, so an EXE-forward from a load must wait.
  assign lu_c = bus.ID_valid & bus.EXE_is_load &
                ((bus.forwardA == FWD_EXE) | (bus.forwardB == FWD_EXE));
  // An empty ID slot is captured exactly like an inserted bubble.
  assign bubble_c  = bus.flush | lu_c | ~bus.ID_valid;
  assign bus.stall = lu_c & ~bus.flush;

  // Pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_valid <= 1'b0;
      exe_inst  <= DW'(NOP_INST);
      exe_pc4   <= '0;
      exe_opa   <= '0;
      exe_opb   <= '0;
    end else if (!bus.hold) begin
      if (bubble_c) begin
        exe_valid <= 1'b0;
        exe_inst  <= DW'(NOP_INST);
        exe_pc4   <= '0;
        exe_opa   <= '0;
        exe_opb   <= '0;
      end else begin
        exe_valid <= 1'b1;
        exe_inst  <= bus.ID_inst;
        exe_pc4   <= bus.ID_pc4;
        exe_opa   <= opa_c;
        exe_opb   <= opb_c;
      end
    end
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!bus.hold) begin
      if (bus.cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (bus.stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CW'(1);
        if (bus.flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CW'(1);
      end
    end
  end

  assign bus.EXE_valid = exe_valid;
  assign bus.EXE_inst  = exe_inst;
  assign bus.EXE_pc4   = exe_pc4;
  assign bus.EXE_opA   = exe_opa;
  assign bus.EXE_opB   = exe_opb;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_id_exe_operand_reg.sv
// Bench for id_exe_operand_reg: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a behavioural model.
module tb_id_exe_operand_reg;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;
  localparam int          NV   = 12;

  logic clk = 1'b0;
  logic rst;

  id_exe_operand_reg_if #(.DW(DW), .CW(CW)) bus ();
  id_exe_operand_reg #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [31:0] m_inst, m_pc4, m_opa, m_opb;
  int          m_sc, m_fc;

  typedef struct {
    logic        hold, flush, valid, load, clr;
    logic [1:0]  fa, fb;
    logic [31:0] mem;
    logic        e_stall, e_valid;
    logic [31:0] e_opa, e_opb;
    int          e_sc, e_fc;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic [31:0] opa,
                          input logic [31:0] opb, input int sc, input int fc);
    chk({tag, ".valid"}, 32'(bus.EXE_valid), 32'(v));
    chk({tag, ".inst"},  bus.EXE_inst, inst);
    chk({tag, ".pc4"},   bus.EXE_pc4, pc4);
    chk({tag, ".opA"},   bus.EXE_opA, opa);
    chk({tag, ".opB"},   bus.EXE_opB, opb);
    chk({tag, ".scnt"},  32'(bus.stall_cnt), 32'(sc));
    chk({tag, ".fcnt"},  32'(bus.flush_cnt), 32'(fc));
  endtask

  task automatic idle();
    bus.hold = 0; bus.flush = 0; bus.ID_valid = 0; bus.ID_inst = '0; bus.ID_pc4 = '0;
    bus.forwardA = 0; bus.forwardB = 0; bus.rf_rdata_a = '0; bus.rf_rdata_b = '0;
    bus.EXE_result = '0; bus.EXE_is_load = 0; bus.MEM_result = '0; bus.WB_result = '0;
    bus.cnt_clr = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_inst = '0; m_pc4 = '0; m_opa = '0; m_opb = '0; m_sc = 0; m_fc = 0;
  endtask

  function automatic logic model_lu();
    return bus.ID_valid && bus.EXE_is_load && (bus.forwardA == 2'd1 || bus.forwardB == 2'd1);
  endfunction

  function automatic logic model_stall();
    return model_lu() && !bus.flush;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] src_a [4];
    logic [31:0] src_b [4];
    logic        st;
    src_a = '{bus.rf_rdata_a, bus.EXE_result, bus.MEM_result, bus.WB_result};
    src_b = '{bus.rf_rdata_b, bus.EXE_result, bus.MEM_result, bus.WB_result};
    st = model_stall();
    if (bus.hold) return;
    if (bus.flush || model_lu() || !bus.ID_valid) begin
      m_valid = 0; m_inst = '0; m_pc4 = '0; m_opa = '0; m_opb = '0;
    end else begin
      m_valid = 1; m_inst = bus.ID_inst; m_pc4 = bus.ID_pc4;
      m_opa = src_a[bus.forwardA]; m_opb = src_b[bus.forwardB];
    end
    if (bus.cnt_clr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (st && m_sc < CMAX) m_sc++;
      if (bus.flush && m_fc < CMAX) m_fc++;
    end
  endtask

  initial begin
    logic [31:0] inst, pc4;
    idle();
    rst = 1'b1;
    model_reset();

    vecs[0]  = '{0,0,1,0,0, 2'd0,2'd3, 32'h33,   0,1, 32'h11, 32'h44,   0,0};
    vecs[1]  = '{0,0,1,0,0, 2'd1,2'd3, 32'h33,   0,1, 32'h22, 32'h44,   0,0};
    vecs[2]  = '{0,0,1,0,0, 2'd2,2'd3, 32'h33,   0,1, 32'h33, 32'h44,   0,0};
    vecs[3]  = '{0,0,1,0,0, 2'd3,2'd3, 32'h33,   0,1, 32'h44, 32'h44,   0,0};
    vecs[4]  = '{0,0,1,1,0, 2'd0,2'd1, 32'h33,   1,0, 32'h0,  32'h0,    1,0};
    vecs[5]  = '{0,0,1,0,0, 2'd0,2'd2, 32'hBEEF, 0,1, 32'h11, 32'hBEEF, 1,0};
    vecs[6]  = '{0,1,1,1,0, 2'd1,2'd0, 32'h33,   0,0, 32'h0,  32'h0,    1,1};
    vecs[7]  = '{0,0,0,1,0, 2'd1,2'd0, 32'h33,   0,0, 32'h0,  32'h0,    1,1};
    vecs[8]  = '{0,0,1,1,1, 2'd1,2'd0, 32'h33,   1,0, 32'h0,  32'h0,    0,0};
    vecs[9]  = '{1,1,1,0,0, 2'd0,2'd0, 32'h33,   0,0, 32'h0,  32'h0,    0,0};
    vecs[10] = '{0,1,0,0,0, 2'd0,2'd0, 32'h33,   0,0, 32'h0,  32'h0,    0,1};
    vecs[11] = '{0,0,1,0,0, 2'd0,2'd0, 32'h33,   0,1, 32'h11, 32'h55,   0,1};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk_outs("reset", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      inst = 32'h1000_0000 + 32'(i);
      pc4  = 32'h400 + 32'(4 * i);
      bus.hold = vecs[i].hold; bus.flush = vecs[i].flush; bus.ID_valid = vecs[i].valid;
      bus.EXE_is_load = vecs[i].load; bus.cnt_clr = vecs[i].clr;
      bus.forwardA = vecs[i].fa; bus.forwardB = vecs[i].fb;
      bus.rf_rdata_a = 32'h11; bus.rf_rdata_b = 32'h55; bus.EXE_result = 32'h22;
      bus.MEM_result = vecs[i].mem; bus.WB_result = 32'h44;
      bus.ID_inst = inst; bus.ID_pc4 = pc4;
      #1 chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk_outs($sformatf("tbl%0d", i), vecs[i].e_valid,
               vecs[i].e_valid ? inst : 32'h0, vecs[i].e_valid ? pc4 : 32'h0,
               vecs[i].e_opa, vecs[i].e_opb, vecs[i].e_sc, vecs[i].e_fc);
    end

    // Hold freezes everything, even with flush and changing inputs
    @(negedge clk); idle();
    bus.ID_valid = 1; bus.rf_rdata_a = 32'h77; bus.rf_rdata_b = 32'h88;
    bus.ID_inst = 32'hAAAA; bus.ID_pc4 = 32'h100;
    @(posedge clk); #1;
    chk_outs("hold_pre", 1, 32'hAAAA, 32'h100, 32'h77, 32'h88, 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.hold = 1; bus.flush = 1; bus.rf_rdata_a = 32'h500 + 32'(k);
      bus.ID_inst = 32'hC000 + 32'(k);
      @(posedge clk); #1;
      chk_outs($sformatf("hold%0d", k), 1, 32'hAAAA, 32'h100, 32'h77, 32'h88, 0, 1);
    end
    @(negedge clk);
    bus.hold = 0; bus.flush = 0; bus.rf_rdata_a = 32'h99; bus.ID_inst = 32'hBBBB; bus.ID_pc4 = 32'h104;
    @(posedge clk); #1;
    chk_outs("hold_rel", 1, 32'hBBBB, 32'h104, 32'h99, 32'h88, 0, 1);

    // Stall counter saturation, then clear alongside a stall
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); idle();
      bus.ID_valid = 1; bus.EXE_is_load = 1; bus.forwardA = 2'd1;
      #1 chk($sformatf("sat%0d.stall", k), 32'(bus.stall), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.scnt", k), 32'(bus.stall_cnt), 32'(k < CMAX ? k : CMAX));
    end
    @(negedge clk); bus.cnt_clr = 1;
    @(posedge clk); #1;
    chk("clr.scnt", 32'(bus.stall_cnt), 32'h0);
    chk("clr.fcnt", 32'(bus.flush_cnt), 32'h0);

    // Asynchronous reset mid-operation
    @(negedge clk); bus.cnt_clr = 0;
    @(posedge clk); #1;
    @(negedge clk); idle();
    bus.ID_valid = 1; bus.rf_rdata_a = 32'h1234; bus.ID_inst = 32'h5; bus.ID_pc4 = 32'h8;
    @(posedge clk); #1;
    chk_outs("pre_rst", 1, 32'h5, 32'h8, 32'h1234, 32'h0, 1, 0);
    @(negedge clk); rst = 1'b1;
    #1 chk_outs("async_rst", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk); idle(); rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.hold        = ($urandom_range(0, 7) == 0);
      bus.flush       = ($urandom_range(0, 5) == 0);
      bus.ID_valid    = ($urandom_range(0, 3) != 0);
      bus.EXE_is_load = ($urandom_range(0, 2) == 0);
      bus.cnt_clr     = ($urandom_range(0, 31) == 0);
      bus.forwardA    = 2'($urandom_range(0, 3));
      bus.forwardB    = 2'($urandom_range(0, 3));
      bus.ID_inst     = $urandom; bus.ID_pc4 = $urandom;
      bus.rf_rdata_a  = $urandom; bus.rf_rdata_b = $urandom;
      bus.EXE_result  = $urandom; bus.MEM_result = $urandom; bus.WB_result = $urandom;
      #1 chk($sformatf("rnd%0d.stall", n), 32'(bus.stall), 32'(model_stall()));
      model_step();
      @(posedge clk); #1;
      chk_outs($sformatf("rnd%0d", n), m_valid, m_inst, m_pc4, m_opa, m_opb, m_sc, m_fc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
